// File: rtl/master_control_pkg.sv
// Chip2Chip shared constants: data width, default notice duration and the
// handshake FSM state encoding used by both master and slave controllers.
package master_control_pkg;

  localparam int DATA_W          = 3;
  localparam int CNT_MAX_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_SEND = 2'd2,
    SEND_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/master_control_sec_timer.sv
// Notice-phase timer: counts while start is held, pulses done (registered)
// on the cycle the count reaches CNT_MAX-1, then wraps.
module sec_timer
  import master_control_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int             CW   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CNT_MAX - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  // done is raised together with the count landing on LAST, so the FSM sees
  // it exactly CNT_MAX cycles after start rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (!start) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/master_control.sv
// Master side of the Chip2Chip handshake: request -> ack -> one-second notice
// -> valid data -> ack, with all outputs registered.
module master_control
  import master_control_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                send,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                ack,
  output logic                request,
  output logic                notice,
  output logic                valid,
  output logic [DATA_W-1:0]   data_out,
  output logic [1:0]          state_dbg
);

  // Handshake: request is a level held until the slave acks; valid is a
  // level held with data_out stable until the slave's second ack. Any
  // synchronized ack cycle counts, but only in WAIT_ACK and SEND_DATA.

  state_t              state, state_nxt;
  logic                ack_meta, ack_s;
  logic                start, start_nxt;
  logic                done;
  logic                request_nxt, notice_nxt, valid_nxt;
  logic [DATA_W-1:0]   data_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_s    <= ack_meta;
    end
  end

  sec_timer #(.CNT_MAX(CNT_MAX)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      request  <= 1'b0;
      notice   <= 1'b0;
      valid    <= 1'b0;
      start    <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_nxt;
      request  <= request_nxt;
      notice   <= notice_nxt;
      valid    <= valid_nxt;
      start    <= start_nxt;
      data_out <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    request_nxt = request;
    notice_nxt  = notice;
    valid_nxt   = valid;
    start_nxt   = start;
    data_nxt    = data_out;
    case (state)
      IDLE: begin
        if (send) begin
          data_nxt    = data_in;
          request_nxt = 1'b1;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          request_nxt = 1'b0;
          notice_nxt  = 1'b1;
          start_nxt   = 1'b1;
          state_nxt   = WAIT_SEND;
        end
      end
      WAIT_SEND: begin
        if (done) begin
          notice_nxt = 1'b0;
          start_nxt  = 1'b0;
          valid_nxt  = 1'b1;
          state_nxt  = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (ack_s) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_master_control.sv
// Directed bench for master_control with CNT_MAX=4: reset, full transfer,
// ignored inputs, stray acks, mid-transfer reset and back-to-back send.
module tb_master_control;

  logic       clk;
  logic       rst_n;
  logic       send;
  logic [2:0] data_in;
  logic       ack;
  logic       request;
  logic       notice;
  logic       valid;
  logic [2:0] data_out;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_WACK = 2'd1, S_WSEND = 2'd2, S_SEND = 2'd3;

  master_control #(.CNT_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .data_in   (data_in),
    .ack       (ack),
    .request   (request),
    .notice    (notice),
    .valid     (valid),
    .data_out  (data_out),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // advance one active edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic ntc,
                         input logic vld, input logic [2:0] d, input logic [1:0] st);
    chk({tag, ".request"},  {3'b0, request}, {3'b0, req});
    chk({tag, ".notice"},   {3'b0, notice},  {3'b0, ntc});
    chk({tag, ".valid"},    {3'b0, valid},   {3'b0, vld});
    chk({tag, ".data_out"}, {1'b0, data_out}, {1'b0, d});
    chk({tag, ".state"},    {2'b0, state_dbg}, {2'b0, st});
  endtask

  // From WAIT_ACK: slave acks, notice runs 4 cycles, ends in SEND_DATA.
  task automatic notice_phase(input string tag, input logic [2:0] d);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all({tag, ".wait_ack"}, 1'b1, 1'b0, 1'b0, d, S_WACK);
    end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk_all({tag, ".ack_m0"}, 1'b1, 1'b0, 1'b0, d, S_WACK);
    cyc();
    chk_all({tag, ".ack_m1"}, 1'b1, 1'b0, 1'b0, d, S_WACK);
    cyc();
    chk_all({tag, ".ack_m2"}, 1'b0, 1'b1, 1'b0, d, S_WSEND);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all({tag, ".notice"}, 1'b0, 1'b1, 1'b0, d, S_WSEND);
    end
    cyc();
    chk_all({tag, ".valid_up"}, 1'b0, 1'b0, 1'b1, d, S_SEND);
  endtask

  // From SEND_DATA: second ack pulse, valid drops 2 cycles later.
  task automatic close_phase(input string tag, input logic [2:0] d);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk_all({tag, ".close0"}, 1'b0, 1'b0, 1'b1, d, S_SEND);
    cyc();
    chk_all({tag, ".close1"}, 1'b0, 1'b0, 1'b1, d, S_SEND);
    cyc();
    chk_all({tag, ".close2"}, 1'b0, 1'b0, 1'b0, d, S_IDLE);
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b1; data_in = 3'b111; ack = 1'b0;
    #1;

    // 1. reset with send held high
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 3'b000, S_IDLE);
    end
    rst_n = 1'b1; send = 1'b0;
    cyc();
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 3'b000, S_IDLE);

    // 4a. stray ack in IDLE
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_all("stray_idle", 1'b0, 1'b0, 1'b0, 3'b000, S_IDLE);
    end

    // 2. full transfer of 3'b101
    data_in = 3'b101; send = 1'b1;
    cyc();
    send = 1'b0; data_in = 3'b010;
    chk_all("accept", 1'b1, 1'b0, 1'b0, 3'b101, S_WACK);
    // 3. send ignored in WAIT_ACK
    send = 1'b1;
    cyc();
    send = 1'b0;
    chk_all("ign_wack", 1'b1, 1'b0, 1'b0, 3'b101, S_WACK);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_all("hold_req", 1'b1, 1'b0, 1'b0, 3'b101, S_WACK);
    end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk_all("t_ack_m0", 1'b1, 1'b0, 1'b0, 3'b101, S_WACK);
    cyc();
    chk_all("t_ack_m1", 1'b1, 1'b0, 1'b0, 3'b101, S_WACK);
    cyc();
    chk_all("t_notice0", 1'b0, 1'b1, 1'b0, 3'b101, S_WSEND);
    // 3/4b. send and stray ack during WAIT_SEND
    send = 1'b1; ack = 1'b1;
    cyc();
    send = 1'b0; ack = 1'b0;
    chk_all("t_notice1", 1'b0, 1'b1, 1'b0, 3'b101, S_WSEND);
    cyc();
    chk_all("t_notice2", 1'b0, 1'b1, 1'b0, 3'b101, S_WSEND);
    cyc();
    chk_all("t_notice3", 1'b0, 1'b1, 1'b0, 3'b101, S_WSEND);
    cyc();
    chk_all("t_valid0", 1'b0, 1'b0, 1'b1, 3'b101, S_SEND);
    // 3. send ignored in SEND_DATA
    send = 1'b1;
    cyc();
    send = 1'b0;
    chk_all("ign_send", 1'b0, 1'b0, 1'b1, 3'b101, S_SEND);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk_all("t_close0", 1'b0, 1'b0, 1'b1, 3'b101, S_SEND);
    // send coincident with the closing ack_s is ignored
    send = 1'b1;
    cyc();
    send = 1'b0;
    chk_all("t_close1", 1'b0, 1'b0, 1'b1, 3'b101, S_SEND);
    cyc();
    chk_all("t_close2", 1'b0, 1'b0, 1'b0, 3'b101, S_IDLE);

    // 6. back-to-back send in the first IDLE cycle
    data_in = 3'b011; send = 1'b1;
    cyc();
    send = 1'b0;
    chk_all("b2b_accept", 1'b1, 1'b0, 1'b0, 3'b011, S_WACK);
    notice_phase("b2b", 3'b011);

    // 5. reset during SEND_DATA
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 3'b000, S_IDLE);
    cyc();
    chk_all("mid_reset_idle", 1'b0, 1'b0, 1'b0, 3'b000, S_IDLE);

    // fresh transfer after reset
    data_in = 3'b110; send = 1'b1;
    cyc();
    send = 1'b0;
    chk_all("fresh_accept", 1'b1, 1'b0, 1'b0, 3'b110, S_WACK);
    notice_phase("fresh", 3'b110);
    close_phase("fresh", 3'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_control.md
# master_control

Master-side handshake controller for the Chip2Chip link, directly upstream of the slave controller on the other board. On a one-cycle `send` strobe from the button front end, it latches the 3-bit switch value and raises `request`. After the slave's first `ack`, it shows `notice` for one second. It then presents the latched data with `valid` until the slave's second `ack` closes the transfer.

## Interface
- `CNT_MAX`, default 100_000_000: notice duration in clk cycles (1 s at 100 MHz).
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset; synchronous, active-low; clock `clk`.
- `send`  input  1  one-cycle strobe (already debounced and one-pulsed) requesting a transfer.
- `data_in`  input  3  switch value, sampled when `send` is accepted.
- `ack`  input  1  acknowledge pin from slave board; asynchronous to `clk`.
- `request`  output  1  request to slave, level.
- `notice`  output  1  LED indication, high for `CNT_MAX` cycles after the first ack.
- `valid`  output  1  `data_out` is valid for the slave to sample.
- `data_out`  output  3  latched transfer data to slave pins.

## Operation
- `ack` passes through a 2-flop synchronizer, giving `ack_s`.
  - The FSM uses only `ack_s`.
  - Any cycle with `ack_s`=1 counts as an acknowledge. Slave ack pulses are one slave-clock cycle wide; board clocks are nominally equal.
- States, 2-bit encoding: IDLE=0, WAIT_ACK=1, WAIT_SEND=2, SEND_DATA=3.
- IDLE:
  - When `send`=1: latch `data_in` into `data_out`, set `request`=1, go to WAIT_ACK.
  - Otherwise all outputs hold; `data_out` keeps its last value.
- WAIT_ACK:
  - `request` is held at 1 until `ack_s`=1.
  - On `ack_s`=1: `request`=0, `notice`=1, timer start=1, go to WAIT_SEND.
  - No timeout; `request` is held indefinitely.
- WAIT_SEND:
  - `notice`=1 and timer start=1 while `done`=0.
  - On `done`=1: `notice`=0, start=0, `valid`=1, go to SEND_DATA.
- SEND_DATA:
  - `valid` is held at 1 until `ack_s`=1.
  - On `ack_s`=1: `valid`=0, go to IDLE.
- `send` in any state other than IDLE is ignored. `data_in` changes after acceptance do not affect `data_out`.
- `ack_s` seen in IDLE or WAIT_SEND is ignored. A stray or late slave pulse must not advance the FSM.
- All outputs are registered: next-state/next-output logic is combinational, updated on posedge `clk`.

## Timing
- Reset values: `request`=0, `notice`=0, `valid`=0, `data_out`=0, state=IDLE, synchronizer flops=0, timer count=0.
- Reset asserted mid-transfer returns to IDLE in the next cycle and drops all outputs to 0.
- `send` high at edge N: `request`=1 and `data_out`=`data_in` from cycle N+1.
- `ack` pin rises before edge M:
  - `ack_s` is high after edge M+1.
  - `request` falls and `notice` rises at edge M+2.
- Notice phase:
  - `notice` stays high exactly `CNT_MAX` cycles, ±1 cycle for `done` registration. The exact count is fixed by the timer definition below.
  - `valid` rises on the same edge that `notice` falls.
- Second ack: `valid` falls 2 cycles after the `ack` pin rises (synchronizer latency), then the FSM is back in IDLE.
- `data_out` is stable from request onward, so it is stable at least `CNT_MAX` cycles before `valid`.
- `send` coincident with the `ack_s` that returns the FSM to IDLE is ignored. The next accepted `send` is one in IDLE.

## Structure
- Shared package (Chip2Chip):
  - state encodings,
  - `DATA_W`=3,
  - default `CNT_MAX`.
  These are the same constants the slave controller uses.
- Sub-module `sec_timer` (parameter `CNT_MAX`; ports `clk`, `rst_n`, `start`, `done`):
  - The count increments while `start`=1 and clears to 0 whenever `start`=0.
  - `done`=1, registered, for one cycle when the count reaches `CNT_MAX`-1; the count then wraps to 0.
  - Timer width is $clog2(`CNT_MAX`).
- The synchronizer is inline: two flops, no separate module.

## Test plan
All scenarios use `CNT_MAX`=4.
1. Reset: hold `rst_n`=0 for 3 cycles with `send`=1 -> all outputs 0 and the FSM in IDLE after release.
2. Full transfer:
   - Stimulus: `data_in`=3'b101, `send` pulse; slave model pulses `ack` 10 cycles later and again 2 cycles after `valid` rises.
   - Required: `request` rises at N+1; `notice` is high for 4 cycles; `valid` is high with `data_out`=3'b101 until 2 cycles after the second ack pulse; FSM back in IDLE.
3. Ignored inputs: `send` pulses and `data_in`=3'b010 during WAIT_ACK, WAIT_SEND and SEND_DATA -> `data_out` stays 3'b101 and the FSM is unaffected.
4. Stray ack: `ack` pulse in IDLE and mid-WAIT_SEND -> no state change; `notice` duration still 4 cycles.
5. Reset mid-operation: assert `rst_n`=0 during SEND_DATA -> `valid`=0 and `data_out`=0 next cycle; a fresh transfer afterwards completes normally.
6. Back-to-back: a second `send` in the cycle after returning to IDLE -> accepted, `request`=1 on the following cycle.
